// File: rtl/input_cond_pkg.sv
// Shared types, constants and helpers for the input conditioning front-end.
// Default timings assume a 50 MHz mclk.
package input_cond_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_RATE     = 5000000;   // 100 ms

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: synchroniser, counter debounce and registered
// rise/fall pulses aligned with the first cycle of the new level.
module debounce_ch
    import input_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic mclk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   q_q;
    logic [CW-1:0]          c_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != q_q) && (c_q == C_LAST);

    always_ff @(posedge mclk) begin
        if (rst) begin
            sync_q <= '0;
            q_q    <= 1'b0;
            c_q    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise_q <= accept && s;
            fall_q <= accept && !s;
            if (s == q_q) begin
                c_q <= '0;
            end else if (accept) begin
                q_q <= s;
                c_q <= '0;
            end else begin
                c_q <= c_q + CW'(1);
            end
        end
    end

    assign level = q_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_cond.sv
// Debounced switch and push-button front-end with per-button auto-repeat.
// Produces clean levels plus one-cycle change/press/release pulses.
module input_cond
    import input_cond_pkg::*;
#(
    parameter int unsigned     N_SW            = 8,
    parameter int unsigned     N_BTN           = 4,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned     REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned     REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [N_BTN-1:0] REPEAT_MASK    = '0
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw_in,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_SW-1:0]  sw_out,
    output logic [N_SW-1:0]  sw_change,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW    = clog2(R_MAX + 1);
    localparam logic [RW-1:0] R_DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [N_SW-1:0]  sw_rise;
    logic [N_SW-1:0]  sw_fall;
    logic [N_BTN-1:0] btn_rise;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .mclk (mclk),
            .rst  (rst),
            .raw  (sw_in[i]),
            .level(sw_out[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

    assign sw_change = sw_rise | sw_fall;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        rep_state_e    state_q, state_d;
        logic [RW-1:0] r_q, r_d;
        logic          rep_q, rep_d;

        debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .mclk (mclk),
            .rst  (rst),
            .raw  (btn_in[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i]),
            .fall (btn_release[i])
        );

        // The FSM observes acceptance one cycle late through the rise pulse, so
        // HOLD starts with r=1; a release is caught by masking with the level.
        always_comb begin
            state_d = state_q;
            r_d     = r_q;
            rep_d   = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    r_d = '0;
                    if (REPEAT_MASK[i] && btn_rise[i]) begin
                        if (REPEAT_DELAY == 1) begin
                            rep_d   = 1'b1;
                            state_d = ST_REPEAT;
                        end else begin
                            r_d     = RW'(1);
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!btn_level[i]) begin
                        state_d = ST_IDLE;
                        r_d     = '0;
                    end else if (r_q == R_DELAY_LAST) begin
                        rep_d   = 1'b1;
                        r_d     = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!btn_level[i]) begin
                        state_d = ST_IDLE;
                        r_d     = '0;
                    end else if (r_q == R_RATE_LAST) begin
                        rep_d = 1'b1;
                        r_d   = '0;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    r_d     = '0;
                end
            endcase
        end

        always_ff @(posedge mclk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                r_q     <= '0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                r_q     <= r_d;
                rep_q   <= rep_d;
            end
        end

        assign btn_press[i] = btn_rise[i] | (rep_q & btn_level[i]);
    end

endmodule

// File: tb/tb_input_cond.sv
// Self-checking bench for input_cond: expected pulses are queued with their
// due cycle when stimulus is applied and compared every cycle.
module tb_input_cond;

    localparam int unsigned N_SW  = 8;
    localparam int unsigned N_BTN = 4;

    logic             mclk;
    logic             rst;
    logic [N_SW-1:0]  sw_in;
    logic [N_BTN-1:0] btn_in;
    logic [N_SW-1:0]  sw_out;
    logic [N_SW-1:0]  sw_change;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    input_cond #(
        .N_SW           (N_SW),
        .N_BTN          (N_BTN),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .REPEAT_MASK    (4'b0001)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .sw_in      (sw_in),
        .btn_in     (btn_in),
        .sw_out     (sw_out),
        .sw_change  (sw_change),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [N_SW-1:0]  sw;
        logic [N_BTN-1:0] pr;
        logic [N_BTN-1:0] rl;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    bit   chk_en  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_exp(input int due, input logic [N_SW-1:0] sw,
                            input logic [N_BTN-1:0] pr, input logic [N_BTN-1:0] rl);
        exp_t e;
        e.due = due;
        e.sw  = sw;
        e.pr  = pr;
        e.rl  = rl;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    logic [N_SW-1:0]  e_sw;
    logic [N_BTN-1:0] e_pr;
    logic [N_BTN-1:0] e_rl;

    always @(negedge mclk) begin
        if (chk_en) begin
            e_sw = '0;
            e_pr = '0;
            e_rl = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    e_sw = e_sw | sb[i].sw;
                    e_pr = e_pr | sb[i].pr;
                    e_rl = e_rl | sb[i].rl;
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    check_val("stale_entry", 32'(sb[i].due), 32'(cyc));
                    sb.delete(i);
                end
            end
            check_val("sw_change", 32'(sw_change), 32'(e_sw));
            check_val("btn_press", 32'(btn_press), 32'(e_pr));
            check_val("btn_release", 32'(btn_release), 32'(e_rl));
        end
    end

    int p;
    int a;

    initial begin
        rst    = 1'b1;
        sw_in  = '0;
        btn_in = '0;
        wait_cyc(3);
        check_val("rst_sw_out", 32'(sw_out), 32'h0);
        check_val("rst_btn_level", 32'(btn_level), 32'h0);
        check_val("rst_pulses", 32'({sw_change, btn_press, btn_release}), 32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;
        wait_cyc(2);

        // Button 0 press, auto-repeat, release landing on a would-be repeat slot.
        p = cyc;
        a = p + 6;
        btn_in[0] = 1'b1;
        push_exp(a, '0, 4'b0001, '0);
        push_exp(a + 10, '0, 4'b0001, '0);
        push_exp(a + 13, '0, 4'b0001, '0);
        push_exp(a + 16, '0, 4'b0001, '0);
        push_exp(a + 19, '0, 4'b0001, '0);
        push_exp(a + 22, '0, 4'b0001, '0);
        push_exp(a + 25, '0, '0, 4'b0001);
        wait_cyc(5);
        check_val("t1_level_early", 32'(btn_level), 32'h0);
        wait_cyc(1);
        check_val("t1_level", 32'(btn_level), 32'h1);
        wait_cyc(a + 19 - cyc);
        btn_in[0] = 1'b0;
        wait_cyc(6);
        check_val("t3_level_rel", 32'(btn_level), 32'h0);
        wait_cyc(20);

        // Switch 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
        sw_in[3] = 1'b1;
        wait_cyc(3);
        sw_in[3] = 1'b0;
        wait_cyc(10);
        check_val("t2_glitch", 32'(sw_out), 32'h0);
        p = cyc;
        sw_in[3] = 1'b1;
        push_exp(p + 6, 8'h08, '0, '0);
        wait_cyc(4);
        sw_in[3] = 1'b0;
        push_exp(p + 10, 8'h08, '0, '0);
        wait_cyc(2);
        check_val("t2_sw_high", 32'(sw_out), 32'h08);
        wait_cyc(4);
        check_val("t2_sw_low", 32'(sw_out), 32'h0);
        wait_cyc(10);

        // Button 1 without repeat enable: single press over a long hold.
        p = cyc;
        btn_in[1] = 1'b1;
        push_exp(p + 6, '0, 4'b0010, '0);
        wait_cyc(50);
        check_val("t4_level", 32'(btn_level), 32'h2);
        btn_in[1] = 1'b0;
        push_exp(cyc + 6, '0, '0, 4'b0010);
        wait_cyc(6);
        check_val("t4_level_rel", 32'(btn_level), 32'h0);
        wait_cyc(10);

        // Reset while button 0 is repeating, input held high throughout.
        p = cyc;
        a = p + 6;
        btn_in[0] = 1'b1;
        push_exp(a, '0, 4'b0001, '0);
        push_exp(a + 10, '0, 4'b0001, '0);
        push_exp(a + 13, '0, 4'b0001, '0);
        wait_cyc(a + 14 - cyc);
        rst = 1'b1;
        wait_cyc(1);
        check_val("t5_rst_levels", 32'({sw_out, btn_level}), 32'h0);
        check_val("t5_rst_pulses", 32'({sw_change, btn_press, btn_release}), 32'h0);
        rst = 1'b0;
        p = cyc;
        push_exp(p + 6, '0, 4'b0001, '0);
        wait_cyc(5);
        check_val("t5_level_early", 32'(btn_level), 32'h0);
        wait_cyc(1);
        check_val("t5_level", 32'(btn_level), 32'h1);
        wait_cyc(2);
        btn_in[0] = 1'b0;
        push_exp(cyc + 6, '0, '0, 4'b0001);
        wait_cyc(16);

        // Every channel toggles in the same cycle.
        p = cyc;
        sw_in  = '1;
        btn_in = '1;
        push_exp(p + 6, 8'hff, 4'hf, '0);
        wait_cyc(6);
        check_val("t6_sw_all", 32'(sw_out), 32'hff);
        check_val("t6_btn_all", 32'(btn_level), 32'hf);
        wait_cyc(2);
        sw_in  = '0;
        btn_in = '0;
        push_exp(p + 14, 8'hff, '0, 4'hf);
        wait_cyc(6);
        check_val("t6_sw_off", 32'(sw_out), 32'h0);
        check_val("t6_btn_off", 32'(btn_level), 32'h0);
        wait_cyc(20);

        check_val("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/input_cond.md
Name: input_cond

Overview:
- Parametrised front-end conditioning for board switches and push-buttons.
- Each channel goes through a synchroniser, a counter debounce and edge detection.
- Buttons also have optional auto-repeat.
- Sits between board pins and the calculator core. Replaces the bare two-flop synchronisers so the core sees clean levels and one-cycle press/release pulses.

Parameters:
- N_SW, 8, number of switch channels (>=1)
- N_BTN, 4, number of button channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 500000, cycles the synchronised input must differ from stable state before accepted (>=1)
- REPEAT_DELAY, 25000000, cycles a button is held after press before first repeat pulse (>=1)
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=1)
- REPEAT_MASK, 4'b0000, per-button auto-repeat enable, width N_BTN

Ports:
- mclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_in  in  N_SW  raw asynchronous switches
- btn_in  in  N_BTN  raw asynchronous buttons
- sw_out  out  N_SW  debounced switch levels
- sw_change  out  N_SW  one-cycle pulse when corresponding sw_out changes
- btn_level  out  N_BTN  debounced button levels
- btn_press  out  N_BTN  one-cycle pulse on press and on each auto-repeat
- btn_release  out  N_BTN  one-cycle pulse on release

Behaviour:
- Reset: one clock; reset is synchronous and active-high on mclk. While rst is high at a mclk edge, every register clears to 0 at that edge: sync chains, stable states, debounce counters, repeat counters and all outputs.
- Reset mid-operation: counts and pending pulses are discarded. An input still high after reset re-debounces and produces a fresh press/change after the full latency.
- Synchroniser: SYNC_STAGES flops in series. Output s is the last stage.
- Debounce, per channel, with stable state q and counter c (width clog2(DEBOUNCE_CYCLES+1)):
  - s == q: c <= 0.
  - s != q and c < DEBOUNCE_CYCLES-1: c <= c+1.
  - s != q and c == DEBOUNCE_CYCLES-1: q <= s, c <= 0, and the edge flag is registered in the same edge.
  - A glitch shorter than DEBOUNCE_CYCLES resets c and never changes q.
  - DEBOUNCE_CYCLES=1: q follows s with one cycle delay.
- Latency: a raw step held steady changes q exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples it.
- Edges: sw_change, btn_press and btn_release are registered. Each is high only in the first cycle in which the new q level is visible on the level output. Never wider than one cycle.
- Auto-repeat, per button with REPEAT_MASK bit set; counter r (width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)):
  - States: IDLE (q=0), HOLD (waiting REPEAT_DELAY), REPEAT (waiting REPEAT_RATE).
  - IDLE -> HOLD on accepted press, r <= 0.
  - HOLD: r increments each cycle. When r == REPEAT_DELAY-1: pulse btn_press, r <= 0, go to REPEAT.
  - REPEAT: when r == REPEAT_RATE-1: pulse btn_press, r <= 0.
  - Any state -> IDLE on accepted release, r <= 0. No repeat pulse is issued in the release cycle.
  - Mask bit clear: the channel stays in IDLE and only the initial press pulses.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- No pulse is ever generated purely by reset deassertion.

Decomposition:
- Package input_cond_pkg:
  - clog2 function
  - repeat state encoding (ST_IDLE, ST_HOLD, ST_REPEAT)
  - default timing constants for 50 MHz mclk (10 ms debounce, 500 ms delay, 100 ms rate)
- Sub-module debounce_ch:
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES.
  - Ports: mclk, rst, raw, level, rise, fall.
  - Instantiated N_SW+N_BTN times via generate.
- The repeat FSM lives in input_cond, generated per button.

Test Plan:
1. Use DEBOUNCE_CYCLES=4, SYNC_STAGES=2. Raise btn_in[0] and hold -> btn_level[0] rises 6 edges later; btn_press[0] high that one cycle only; no btn_release.
2. Pulse sw_in[3] high for 3 cycles then low -> sw_out and sw_change stay 0 throughout. Then hold it high for 4 cycles -> sw_out[3]=1 with a single sw_change[3] pulse.
3. Use REPEAT_MASK=4'b0001, REPEAT_DELAY=10, REPEAT_RATE=3, hold btn0 -> press pulses at acceptance, +10, +13, +16 cycles. Release -> btn_release pulse and no further presses.
4. Same settings on btn1 (mask bit clear), held 50 cycles -> exactly one btn_press[1].
5. Assert rst for 1 cycle while btn0 is in REPEAT with inputs still high -> all outputs 0 at the next edge. After deassertion, btn_level[0] reasserts after 6 cycles with one press pulse.
6. Toggle all 8 switches and 4 buttons in the same cycle -> all change/press pulses assert in the same cycle.
